// File: rtl/spi_flash_reader_if.sv
// User-side bundle of the SPI flash reader: read request in, byte stream out.
// Latency: none, plain wiring between user logic and the reader.
// Backpressure: data_valid/data_ready handshake on the byte stream; start is ignored while busy.
interface spi_flash_reader_if #(
  parameter int LEN_W = 16
);
  logic             start;
  logic [23:0]      addr;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             done;
  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready;

  // User logic: issues reads and consumes bytes
  modport master (
    output start, addr, len, data_ready,
    input  busy, done, data_out, data_valid
  );

  // Flash reader: accepts reads and produces bytes
  modport slave (
    input  start, addr, len, data_ready,
    output busy, done, data_out, data_valid
  );
endinterface

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master streaming len bytes from the config flash (READ 0x03, or FAST_READ 0x0B with a
// dummy byte when SPI_FLASH_FAST_READ_EN is defined). Latency: first byte 80 cycles after CS falls at CLK_DIV=1.
// Backpressure: single output register; SCLK holds low before a byte's first rising edge until data_out drains.
module spi_flash_reader #(
  parameter int CLK_DIV        = 1,
  parameter int LEN_W          = 16,
  parameter int CS_HIGH_CYCLES = 4
) (
  input  logic                clock_12mhz,
  input  logic                reset,
  spi_flash_reader_if.slave   bus,
  output logic                flash_cs,
  output logic                flash_sclk,
  output logic                flash_mosi,
  input  logic                flash_miso
);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] READ_CMD = 8'h0B;
`else
  localparam logic [7:0] READ_CMD = 8'h03;
`endif

  localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [15:0] DESEL_LAST = 16'((CS_HIGH_CYCLES > 0) ? CS_HIGH_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
`ifdef SPI_FLASH_FAST_READ_EN
    S_DUMMY,
`endif
    S_DATA,
    S_DESEL
  } state_t;

  state_t           state_q, state_d;
  logic [7:0]       div_q, div_d;
  logic [4:0]       bit_q, bit_d;
  logic [31:0]      sh_out_q, sh_out_d;
  logic [7:0]       sh_in_q, sh_in_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic             full_q, full_d;
  logic [15:0]      desel_q, desel_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       dout_q, dout_d;
  logic             dvld_q, dvld_d;

  logic             accept;
  logic             tick;
  logic             shifting;
  logic             stall;
  logic [4:0]       last_bit;
  state_t           next_phase;

  // Next-state, serial bit engine and output-register logic
  always_comb begin
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sh_out_d = sh_out_q;
    sh_in_d  = sh_in_q;
    left_d   = left_q;
    full_d   = full_q;
    desel_d  = desel_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    dvld_d   = dvld_q;
    shifting = 1'b0;
    stall    = 1'b0;
    last_bit = 5'd7;
    next_phase = S_DATA;

    accept = dvld_q & bus.data_ready;
    tick   = (div_q == DIV_LAST);

    // Output register drains on acceptance and refills from a completed byte
    if (accept) dvld_d = 1'b0;
    if (full_q) begin
      dout_d = sh_in_q;
      dvld_d = 1'b1;
      full_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d  = S_CMD;
            busy_d   = 1'b1;
            cs_d     = 1'b0;
            sclk_d   = 1'b0;
            sh_out_d = {READ_CMD, bus.addr};
            mosi_d   = READ_CMD[7];
            bit_d    = 5'd0;
            div_d    = 8'd0;
            left_d   = bus.len;
          end
        end
      end
      S_CMD: begin
        shifting   = 1'b1;
        next_phase = S_ADDR;
      end
      S_ADDR: begin
        shifting = 1'b1;
        last_bit = 5'd23;
`ifdef SPI_FLASH_FAST_READ_EN
        next_phase = S_DUMMY;
`else
        next_phase = S_DATA;
`endif
      end
`ifdef SPI_FLASH_FAST_READ_EN
      S_DUMMY: begin
        shifting   = 1'b1;
        next_phase = S_DATA;
      end
`endif
      S_DATA: begin
        if (left_q != '0) begin
          shifting = 1'b1;
        end else if (!full_q && (!dvld_q || accept)) begin
          // Last byte has been handed over: release the flash
          state_d = S_DESEL;
          cs_d    = 1'b1;
          desel_d = 16'd0;
        end
      end
      S_DESEL: begin
        desel_d = desel_q + 16'd1;
        if (desel_q >= DESEL_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    if (shifting) begin
      if (!tick) begin
        div_d = div_q + 8'd1;
      end else if (!sclk_q) begin
        // A new data byte may only start once the previous one has left data_out
        stall = (state_q == S_DATA) && (bit_q == 5'd0) && dvld_q && !accept;
        if (!stall) begin
          div_d  = 8'd0;
          sclk_d = 1'b1;
          if (state_q == S_DATA) begin
            sh_in_d = {sh_in_q[6:0], flash_miso};
            if (bit_q == 5'd7) full_d = 1'b1;
          end
        end
      end else begin
        div_d    = 8'd0;
        sclk_d   = 1'b0;
        sh_out_d = {sh_out_q[30:0], 1'b0};
        mosi_d   = (state_q == S_CMD || state_q == S_ADDR) ? sh_out_q[30] : 1'b0;
        bit_d    = bit_q + 5'd1;
        if (bit_q == last_bit) begin
          bit_d   = 5'd0;
          state_d = next_phase;
          if (state_q == S_DATA) left_d = left_q - 1'b1;
        end
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock_12mhz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      div_q    <= 8'd0;
      bit_q    <= 5'd0;
      sh_out_q <= 32'd0;
      sh_in_q  <= 8'd0;
      left_q   <= '0;
      full_q   <= 1'b0;
      desel_q  <= 16'd0;
      cs_q     <= 1'b1;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dout_q   <= 8'd0;
      dvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sh_out_q <= sh_out_d;
      sh_in_q  <= sh_in_d;
      left_q   <= left_d;
      full_q   <= full_d;
      desel_q  <= desel_d;
      cs_q     <= cs_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dout_q   <= dout_d;
      dvld_q   <= dvld_d;
    end
  end

  assign flash_cs       = cs_q;
  assign flash_sclk     = sclk_q;
  assign flash_mosi     = mosi_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.data_out   = dout_q;
  assign bus.data_valid = dvld_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: behavioural SPI flash plus byte-stream scoreboard.
// Latency: checks first-byte latency and unstalled byte rate at CLK_DIV=1.
// Backpressure: fixed 100-cycle stall and random data_ready patterns.
module tb_spi_flash_reader;
  localparam int LEN_W          = 16;
  localparam int CS_HIGH_CYCLES = 4;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int DUMMY_BITS = 8;
`else
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int DUMMY_BITS = 0;
`endif
  localparam int HDR_BITS = 32 + DUMMY_BITS;

  logic clock_12mhz = 1'b0;
  logic reset = 1'b1;
  logic flash_cs, flash_sclk, flash_mosi;
  logic flash_miso = 1'b0;

  spi_flash_reader_if #(.LEN_W(LEN_W)) bus ();

  spi_flash_reader #(
    .CLK_DIV(1),
    .LEN_W(LEN_W),
    .CS_HIGH_CYCLES(CS_HIGH_CYCLES)
  ) dut (
    .clock_12mhz(clock_12mhz),
    .reset(reset),
    .bus(bus.slave),
    .flash_cs(flash_cs),
    .flash_sclk(flash_sclk),
    .flash_mosi(flash_mosi),
    .flash_miso(flash_miso)
  );

  always #5 clock_12mhz = ~clock_12mhz;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural flash: header collected on SCLK rise, data shifted out on SCLK fall
  logic [7:0]  mem [0:4095];
  int          nbits = 0;
  logic [31:0] hdr = '0;
  int          tail_ones = 0;
  logic        cs_prev = 1'b1;
  logic        sclk_prev = 1'b0;

  always @(flash_cs or flash_sclk) begin
    logic [7:0] b;
    int k;
    if (cs_prev && !flash_cs) begin
      nbits = 0;
      hdr = '0;
      tail_ones = 0;
      flash_miso = 1'($urandom);
    end else if (!flash_cs && !sclk_prev && flash_sclk) begin
      if (nbits < 32) hdr = {hdr[30:0], flash_mosi};
      else if (flash_mosi) tail_ones++;
      nbits++;
    end else if (!flash_cs && sclk_prev && !flash_sclk) begin
      if (nbits >= HDR_BITS) begin
        k = nbits - HDR_BITS;
        b = mem[(int'(hdr[11:0]) + k / 8) % 4096];
        flash_miso = b[7 - (k % 8)];
      end else begin
        flash_miso = 1'($urandom);
      end
    end
    cs_prev = flash_cs;
    sclk_prev = flash_sclk;
  end

  // Consumer side: data_ready pattern
  int   ready_mode = 0;
  logic ready_hold = 1'b1;
  always @(posedge clock_12mhz) begin
    #1;
    case (ready_mode)
      0:       bus.data_ready = 1'b1;
      1:       bus.data_ready = ($urandom_range(0, 2) != 0);
      default: bus.data_ready = ready_hold;
    endcase
  end

  // Monitor sampled on the falling clock edge
  int         cyc = 0;
  logic [7:0] rx_q [$];
  int         acc_t [$];
  int         done_cnt = 0;
  int         cs_fall_cnt = 0;
  int         cs_fall_t = -1;
  int         first_valid_t = -1;
  int         cs_high_run = 0;
  int         run_at_done = 0;
  logic       busy_at_done = 1'b0;
  logic       cs_mon_prev = 1'b1;

  always @(negedge clock_12mhz) begin
    cyc++;
    if (bus.data_valid && bus.data_ready) begin
      rx_q.push_back(bus.data_out);
      acc_t.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      run_at_done = flash_cs ? cs_high_run : 0;
      busy_at_done = bus.busy;
    end
    if (flash_cs) cs_high_run++;
    else cs_high_run = 0;
    if (cs_mon_prev && !flash_cs) begin
      cs_fall_cnt++;
      cs_fall_t = cyc;
    end
    if (bus.data_valid && first_valid_t < 0) first_valid_t = cyc;
    cs_mon_prev = flash_cs;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock_12mhz);
    #1;
  endtask

  task automatic start_xfer(input logic [23:0] a, input int n);
    rx_q.delete();
    acc_t.delete();
    first_valid_t = -1;
    cs_fall_t = -1;
    bus.start = 1'b1;
    bus.addr = a;
    bus.len = LEN_W'(n);
    tick(1);
    bus.start = 1'b0;
    bus.addr = 24'($urandom);
    bus.len = LEN_W'($urandom);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int t;
    t = 0;
    while (done_cnt == d0 && t < 5000) begin
      tick(1);
      t++;
    end
    check({tag, "_no_timeout"}, 32'(t < 5000), 32'd1);
  endtask

  task automatic check_stream(input string tag, input logic [23:0] a, input int n, input int d0);
    logic [7:0] g;
    check({tag, "_hdr"}, hdr, {EXP_CMD, a});
    check({tag, "_mosi_zero_after_hdr"}, 32'(tail_ones), 32'd0);
    check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      g = 'x;
      if (i < rx_q.size()) g = rx_q[i];
      check($sformatf("%s_byte%0d", tag, i), 32'(g), 32'(mem[(int'(a[11:0]) + i) % 4096]));
    end
    check({tag, "_cs_high_before_done"}, 32'(run_at_done >= CS_HIGH_CYCLES), 32'd1);
    check({tag, "_busy_low_at_done"}, 32'(busy_at_done), 32'd0);
    tick(3);
    check({tag, "_done_once"}, 32'(done_cnt), 32'(d0 + 1));
  endtask

  initial begin
    int d0;
    int f0;
    int viol;
    int t;
    int n;
    logic [7:0] held;
    logic [23:0] a;

    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    bus.start = 1'b0;
    bus.addr = '0;
    bus.len = '0;
    bus.data_ready = 1'b1;
    reset = 1'b1;
    tick(3);

    check("rst_cs", 32'(flash_cs), 32'd1);
    check("rst_sclk", 32'(flash_sclk), 32'd0);
    check("rst_mosi", 32'(flash_mosi), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_valid", 32'(bus.data_valid), 32'd0);
    check("rst_data", 32'(bus.data_out), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic read with known contents
    mem[12'h345] = 8'hDE;
    mem[12'h346] = 8'hAD;
    mem[12'h347] = 8'hBE;
    mem[12'h348] = 8'hEF;
    d0 = done_cnt;
    start_xfer(24'h012345, 4);
    check("basic_busy", 32'(bus.busy), 32'd1);
    wait_done("basic", d0);
    check("basic_first_latency",
          32'((first_valid_t - cs_fall_t) >= 80 + 2 * DUMMY_BITS &&
              (first_valid_t - cs_fall_t) <= 81 + 2 * DUMMY_BITS), 32'd1);
    check("basic_byte_rate", 32'((acc_t.size() > 1) ? acc_t[1] - acc_t[0] : -1), 32'd16);
    check_stream("basic", 24'h012345, 4, d0);

    // Backpressure: consumer stalls 100 cycles after the first byte appears
    ready_mode = 2;
    ready_hold = 1'b0;
    tick(2);
    d0 = done_cnt;
    a = 24'($urandom);
    start_xfer(a, 3);
    t = 0;
    while (!bus.data_valid && t < 2000) begin
      tick(1);
      t++;
    end
    check("bp_first_valid_seen", 32'(bus.data_valid), 32'd1);
    held = bus.data_out;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (flash_sclk !== 1'b0 || flash_cs !== 1'b0 || bus.data_out !== held || bus.data_valid !== 1'b1)
        viol++;
    end
    check("bp_stall_frozen", 32'(viol), 32'd0);
    ready_hold = 1'b1;
    wait_done("bp", d0);
    check_stream("bp", a, 3, d0);
    ready_mode = 0;

    // Zero-length request
    d0 = done_cnt;
    f0 = cs_fall_cnt;
    bus.start = 1'b1;
    bus.addr = 24'h000123;
    bus.len = '0;
    tick(1);
    bus.start = 1'b0;
    check("len0_done_next", 32'(bus.done), 32'd1);
    check("len0_busy", 32'(bus.busy), 32'd0);
    tick(1);
    check("len0_done_one_cycle", 32'(bus.done), 32'd0);
    tick(10);
    check("len0_cs_never_fell", 32'(cs_fall_cnt), 32'(f0));
    check("len0_done_count", 32'(done_cnt), 32'(d0 + 1));

    // Reset during the address phase
    d0 = done_cnt;
    start_xfer(24'h0ABCDE, 4);
    tick(19);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_cs", 32'(flash_cs), 32'd1);
    check("abort_sclk", 32'(flash_sclk), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.data_valid), 32'd0);
    tick(10);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    d0 = done_cnt;
    start_xfer(24'h000777, 1);
    wait_done("after_abort", d0);
    check_stream("after_abort", 24'h000777, 1, d0);

    // start while busy is ignored
    d0 = done_cnt;
    f0 = cs_fall_cnt;
    start_xfer(24'h000200, 2);
    tick(10);
    bus.start = 1'b1;
    bus.addr = 24'h000900;
    bus.len = LEN_W'(5);
    tick(1);
    bus.start = 1'b0;
    wait_done("rebusy", d0);
    tick(30);
    check("rebusy_one_select", 32'(cs_fall_cnt), 32'(f0 + 1));
    check_stream("rebusy", 24'h000200, 2, d0);

    // Short read at a low address
    d0 = done_cnt;
    start_xfer(24'h000010, 1);
    wait_done("low_addr", d0);
    check_stream("low_addr", 24'h000010, 1, d0);

    // Random reads with random consumer stalls
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      d0 = done_cnt;
      a = 24'($urandom);
      n = $urandom_range(1, 5);
      start_xfer(a, n);
      wait_done($sformatf("rnd%0d", r), d0);
      check_stream($sformatf("rnd%0d", r), a, n, d0);
    end
    ready_mode = 0;
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
